fir_sequencer: RTL and testbench

//   Time-multiplexed FIR controller for the pedal audio path. It accepts one ADC sample per strobe
//   and writes it into an external circular history RAM. It then walks all TAPS taps through one

---
 rtl/fir_sequencer.sv | 154 +++++++++++++++
 tb/tb_fir_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// Time-multiplexed FIR controller: writes each accepted sample to a circular history RAM,
// then walks TAPS taps through one shared MAC. Optional macro FIR_SEQ_ROUND_EN rounds half up.
module fir_sequencer #(
  parameter int unsigned TAPS = 8,
  parameter int unsigned DW   = 12,
  parameter int unsigned CW   = 12,
  localparam int unsigned AW  = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic          busy,
  output logic          overrun,
  output logic          hist_we,
  output logic [AW-1:0] hist_waddr,
  output logic [DW-1:0] hist_wdata,
  output logic [AW-1:0] hist_raddr,
  input  logic [DW-1:0] hist_rdata,
  output logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  output logic [DW-1:0] out_sample
);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned ACCW = PW + AW;
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] TAPS_N = CNTW'(TAPS);

  if (TAPS < 2 || (TAPS & (TAPS - 1)) != 0) begin : g_taps_check
    $error("fir_sequencer: TAPS must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, WRITE, RUN, DONE} state_t;
  state_t state, state_d;

  logic [AW-1:0]          wptr, wptr_d;
  logic [CNTW-1:0]        fill, fill_d;
  logic [CNTW-1:0]        cnt, cnt_d;
  logic signed [ACCW-1:0] acc, acc_d;
  logic                   hist_we_d, busy_d, out_valid_d;
  logic [AW-1:0]          hist_waddr_d, hist_raddr_d, coef_addr_d;
  logic [DW-1:0]          hist_wdata_d, out_sample_d;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_sum, acc_rnd, acc_shr;
  logic [ACCW-DW:0]       acc_hi;
  logic [DW-1:0]          sat_res;

  // MAC: while cnt is 1..TAPS the RAM outputs carry tap (cnt-1); taps at or beyond fill add 0
  always_comb begin
    prod    = PW'($signed(hist_rdata)) * PW'($signed(coef_data));
    acc_sum = ((cnt == CNTW'(1)) ? '0 : acc) + ((cnt <= fill) ? ACCW'(prod) : '0);
`ifdef FIR_SEQ_ROUND_EN
    acc_rnd = acc_sum + ACCW'(2 ** (CW - 2));
`else
    acc_rnd = acc_sum;
`endif
    acc_shr = acc_rnd >>> (CW - 1);
    acc_hi  = acc_shr[ACCW-1:DW-1];
    if (acc_hi == '0 || acc_hi == '1) sat_res = acc_shr[DW-1:0];
    else if (acc_shr[ACCW-1])         sat_res = {1'b1, {(DW-1){1'b0}}};
    else                              sat_res = {1'b0, {(DW-1){1'b1}}};
  end

  always_comb begin
    state_d      = state;
    wptr_d       = wptr;
    fill_d       = fill;
    cnt_d        = cnt;
    acc_d        = acc;
    hist_we_d    = 1'b0;
    hist_waddr_d = hist_waddr;
    hist_wdata_d = hist_wdata;
    hist_raddr_d = hist_raddr;
    coef_addr_d  = coef_addr;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_d      = WRITE;
          hist_we_d    = 1'b1;
          hist_waddr_d = wptr;
          hist_wdata_d = sample_in;
        end
      end
      WRITE: begin
        state_d      = RUN;
        if (fill != TAPS_N) fill_d = fill + CNTW'(1);
        cnt_d        = '0;
        hist_raddr_d = wptr;
        coef_addr_d  = '0;
      end
      // Address phase runs cnt 0..TAPS-1; the extra cycle at cnt=TAPS drains the last read
      RUN: begin
        cnt_d        = cnt + CNTW'(1);
        hist_raddr_d = hist_raddr - AW'(1);
        coef_addr_d  = coef_addr + AW'(1);
        if (cnt != '0) acc_d = acc_sum;
        if (cnt == TAPS_N) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_sample_d = sat_res;
        end
      end
      DONE: begin
        state_d = IDLE;
        wptr_d  = wptr + AW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Strobe rejection must be visible in the same cycle as the dropped strobe
  assign overrun = sample_valid & (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      fill       <= '0;
      cnt        <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      hist_we    <= 1'b0;
      hist_waddr <= '0;
      hist_wdata <= '0;
      hist_raddr <= '0;
      coef_addr  <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      wptr       <= wptr_d;
      fill       <= fill_d;
      cnt        <= cnt_d;
      acc        <= acc_d;
      busy       <= busy_d;
      hist_we    <= hist_we_d;
      hist_waddr <= hist_waddr_d;
      hist_wdata <= hist_wdata_d;
      hist_raddr <= hist_raddr_d;
      coef_addr  <= coef_addr_d;
      out_valid  <= out_valid_d;
      out_sample <= out_sample_d;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: directed scenarios plus randomized traffic
// checked against a sum-of-products reference over the samples accepted since reset.
`timescale 1ns/1ps
module tb_fir_sequencer;
  localparam int TAPS   = 8;
  localparam int DW     = 12;
  localparam int CW     = 12;
  localparam int AW     = 3;
  localparam int LAT    = TAPS + 3;
  localparam int PERIOD = TAPS + 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          busy, overrun, hist_we, out_valid;
  logic [AW-1:0] hist_waddr, hist_raddr, coef_addr;
  logic [DW-1:0] hist_wdata, hist_rdata, out_sample;
  logic [CW-1:0] coef_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .busy(busy), .overrun(overrun), .hist_we(hist_we), .hist_waddr(hist_waddr),
    .hist_wdata(hist_wdata), .hist_raddr(hist_raddr), .hist_rdata(hist_rdata),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
    .out_sample(out_sample)
  );

  // External memories: synchronous history RAM and coefficient ROM, 1-cycle read latency
  logic [DW-1:0]        hist_ram [TAPS];
  logic signed [CW-1:0] coef_rom [TAPS];
  logic                 preload_req = 1'b0;
  logic [DW-1:0]        preload_val = '0;

  always @(posedge clk) begin
    if (preload_req) for (int i = 0; i < TAPS; i++) hist_ram[i] <= preload_val;
    else if (hist_we) hist_ram[hist_waddr] <= hist_wdata;
    hist_rdata <= hist_ram[hist_raddr];
    coef_data  <= coef_rom[coef_addr];
  end

  logic [DW-1:0] outs[$];
  int ovr_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1) outs.push_back(out_sample);
    if (overrun === 1'b1) ovr_cnt++;
  end

  logic signed [DW-1:0] smp_q[$];

  function automatic logic [DW-1:0] ref_fir(input logic signed [DW-1:0] s[$],
                                            input logic signed [CW-1:0] c[TAPS]);
    longint acc = 0;
    longint r;
    int n = s.size();
    for (int i = 0; i < TAPS; i++)
      if (i < n) acc += longint'(s[n-1-i]) * longint'(c[i]);
`ifdef FIR_SEQ_ROUND_EN
    acc += 1024;
`endif
    r = acc >>> 11;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return DW'(r);
  endfunction

  task automatic set_coefs(input logic [CW-1:0] c0, input logic [CW-1:0] rest);
    coef_rom[0] = c0;
    for (int i = 1; i < TAPS; i++) coef_rom[i] = rest;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    smp_q.delete();
    @(negedge clk);
  endtask

  task automatic preload(input logic [DW-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Strobe one sample from idle and wait (bounded) for its result; got stays X on timeout
  task automatic send(input logic [DW-1:0] x, output logic [DW-1:0] got);
    int base = outs.size();
    got = 'x;
    sample_valid = 1'b1;
    sample_in = x;
    smp_q.push_back(x);
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      #3;
      if (outs.size() > base) begin
        got = outs[base];
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    for (int i = 0; i < TAPS; i++) coef_rom[i] = CW'($urandom);
    preload(DW'($urandom));
    @(negedge clk); #3;
    n_cmp++;
    if ({busy, overrun, hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr, out_valid, out_sample} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b we=%b ov=%b out=%h expected all zero", busy, hist_we, out_valid, out_sample);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    n_cmp++;
    if ({busy, out_valid, hist_we} !== 3'b000 || outs.size() != 0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b ov=%b we=%b outs=%0d expected idle", busy, out_valid, hist_we, outs.size());
    end
  endtask

  task automatic test_impulse();
    int lat = -1;
    logic [DW-1:0] got = 'x;
    do_reset();
    set_coefs(12'h400, 12'h000);
    sample_valid = 1'b1;
    sample_in = 12'h200;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      #3;
      if (k == 1) begin
        n_cmp++;
        if ({busy, hist_we, hist_waddr, hist_wdata} !== {1'b1, 1'b1, 3'd0, 12'h200}) begin
          n_err++;
          $display("FAIL impulse_write: got busy=%b we=%b waddr=%0d wdata=%h expected 1 1 0 200", busy, hist_we, hist_waddr, hist_wdata);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if ({hist_raddr, coef_addr} !== {3'd0, 3'd0}) begin
          n_err++;
          $display("FAIL impulse_tap0_addr: got raddr=%0d caddr=%0d expected 0 0", hist_raddr, coef_addr);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if ({hist_raddr, coef_addr} !== {3'd7, 3'd1}) begin
          n_err++;
          $display("FAIL impulse_tap1_addr: got raddr=%0d caddr=%0d expected 7 1", hist_raddr, coef_addr);
        end
      end
      if (out_valid === 1'b1 && lat < 0) begin
        lat = k;
        got = out_sample;
      end
      if (k == LAT + 1) begin
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin
          n_err++;
          $display("FAIL impulse_back_idle: got busy=%b ov=%b expected 0 0", busy, out_valid);
        end
      end
    end
    n_cmp++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL impulse_latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if (got !== 12'h100) begin
      n_err++;
      $display("FAIL impulse_value: got %h expected 100", got);
    end
  endtask

  task automatic test_fill_mask();
    logic [DW-1:0] got;
    logic [DW-1:0] exp_v [3];
    exp_v[0] = 12'd50; exp_v[1] = 12'd100; exp_v[2] = 12'd150;
    do_reset();
    preload(12'h7FF);
    set_coefs(12'h400, 12'h400);
    for (int k = 0; k < 3; k++) begin
      send(12'd100, got);
      n_cmp++;
      if (got !== exp_v[k]) begin
        n_err++;
        $display("FAIL fill_mask[%0d]: got %0d expected %0d", k, got, exp_v[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] got, exp_v;
    do_reset();
    set_coefs(12'h7FF, 12'h7FF);
    for (int k = 0; k < 16; k++) begin
      send((k < 8) ? 12'h7FF : 12'h800, got);
      exp_v = ref_fir(smp_q, coef_rom);
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL saturation_step[%0d]: got %h expected %h", k, got, exp_v);
      end
      if (k == 7 || k == 15) begin
        n_cmp++;
        if (got !== ((k == 7) ? 12'h7FF : 12'h800)) begin
          n_err++;
          $display("FAIL saturation_final[%0d]: got %h expected %h", k, got, (k == 7) ? 12'h7FF : 12'h800);
        end
      end
    end
  endtask

  task automatic test_overrun_wrap();
    int base_o, base_v;
    logic [DW-1:0] exp_v, got;
    do_reset();
    set_coefs(12'h000, 12'h000);
    coef_rom[1] = 12'h400;
    base_o = outs.size();
    base_v = ovr_cnt;
    for (int k = 0; k < 20; k++) begin
      sample_valid = 1'b1;
      sample_in = DW'(k * 8);
      for (int c = 1; c <= PERIOD; c++) begin
        @(negedge clk);
        if (c == 1 || c == 5) sample_valid = 1'b0;
        if (c == 4) begin
          sample_valid = 1'b1;
          sample_in = 12'h5A5;
        end
      end
    end
    repeat (3) @(negedge clk);
    #3;
    n_cmp++;
    if (outs.size() - base_o != 20) begin
      n_err++;
      $display("FAIL overrun_out_count: got %0d expected 20", outs.size() - base_o);
    end
    n_cmp++;
    if (ovr_cnt - base_v != 20) begin
      n_err++;
      $display("FAIL overrun_pulse_count: got %0d expected 20", ovr_cnt - base_v);
    end
    for (int k = 0; k < 20; k++) begin
      exp_v = (k == 0) ? '0 : DW'(4 * (k - 1));
      got = (base_o + k < outs.size()) ? outs[base_o + k] : 'x;
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL overrun_wrap_out[%0d]: got %0d expected %0d", k, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int base_o;
    logic [DW-1:0] got;
    do_reset();
    set_coefs(12'h7FF, 12'h7FF);
    for (int k = 0; k < 5; k++) send(DW'($urandom), got);
    base_o = outs.size();
    sample_valid = 1'b1;
    sample_in = 12'h3C3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) sample_valid = 1'b0;
    end
    reset_n = 1'b0;
    #3;
    n_cmp++;
    if ({busy, overrun, hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr, out_valid, out_sample} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset_outputs: got busy=%b we=%b raddr=%0d out=%h expected all zero", busy, hist_we, hist_raddr, out_sample);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    smp_q.delete();
    repeat (LAT + 2) @(negedge clk);
    #3;
    n_cmp++;
    if (outs.size() != base_o || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_no_output: got outs=%0d busy=%b expected %0d 0", outs.size(), busy, base_o);
    end
    @(negedge clk);
    set_coefs(12'h400, 12'h300);
    send(12'h200, got);
    n_cmp++;
    if (got !== 12'h100) begin
      n_err++;
      $display("FAIL midrun_first_sample: got %h expected 100", got);
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] got, exp_v;
    do_reset();
    set_coefs(12'h001, 12'h000);
`ifdef FIR_SEQ_ROUND_EN
    exp_v = 12'h001;
`else
    exp_v = 12'h000;
`endif
    send(12'h400, got);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL rounding_pos: got %h expected %h", got, exp_v);
    end
    send(12'hC00, got);
    exp_v = ref_fir(smp_q, coef_rom);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL rounding_neg: got %h expected %h", got, exp_v);
    end
  endtask

  // Strobes exactly at the maximum rate, then one strobe landing on the DONE cycle
  task automatic test_back_to_back();
    int base_o, base_v;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v, got;
    do_reset();
    for (int i = 0; i < TAPS; i++) coef_rom[i] = CW'($urandom);
    base_o = outs.size();
    base_v = ovr_cnt;
    for (int k = 0; k < 11; k++) begin
      v = DW'($urandom);
      sample_valid = 1'b1;
      sample_in = v;
      smp_q.push_back(v);
      exp_q.push_back(ref_fir(smp_q, coef_rom));
      for (int c = 1; c <= PERIOD; c++) begin
        @(negedge clk);
        if (c == 1 || c == PERIOD) sample_valid = 1'b0;
        if (k == 10 && c == PERIOD - 1) begin
          sample_valid = 1'b1;
          sample_in = DW'($urandom);
        end
      end
    end
    repeat (LAT + 2) @(negedge clk);
    #3;
    n_cmp++;
    if (outs.size() - base_o != 11 || ovr_cnt - base_v != 1) begin
      n_err++;
      $display("FAIL b2b_counts: got outs=%0d overruns=%0d expected 11 1", outs.size() - base_o, ovr_cnt - base_v);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base_o + i < outs.size()) ? outs[base_o + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_out[%0d]: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int base_o, base_v, last, exp_ovr;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v, got;
    do_reset();
    for (int i = 0; i < TAPS; i++) coef_rom[i] = CW'($urandom);
    preload(DW'($urandom));
    base_o = outs.size();
    base_v = ovr_cnt;
    last = -1000;
    exp_ovr = 0;
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = DW'($urandom);
        sample_valid = 1'b1;
        sample_in = v;
        if (t - last >= PERIOD) begin
          last = t;
          smp_q.push_back(v);
          exp_q.push_back(ref_fir(smp_q, coef_rom));
        end else begin
          exp_ovr++;
        end
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    #3;
    n_cmp++;
    if (outs.size() - base_o != exp_q.size()) begin
      n_err++;
      $display("FAIL random_out_count: got %0d expected %0d", outs.size() - base_o, exp_q.size());
    end
    n_cmp++;
    if (ovr_cnt - base_v != exp_ovr) begin
      n_err++;
      $display("FAIL random_overrun_count: got %0d expected %0d", ovr_cnt - base_v, exp_ovr);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base_o + i < outs.size()) ? outs[base_o + i] : 'x;
      n_cmp++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL random_out[%0d]: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_fill_mask();
    test_saturation();
    test_overrun_wrap();
    test_reset_mid_run();
    test_rounding();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
